// File: rtl/cache_if.sv
// MEM-stage side of the read cache: request/address/data from the pipeline,
// read data and the combinational ready/stall back to it.
interface cache_if;
    logic        r_en;
    logic        w_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output r_en, w_en, address, wdata, input rdata, ready);
    modport slave  (input r_en, w_en, address, wdata, output rdata, ready);
endinterface

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate read cache between
// the MEM stage and the SRAM controller; a miss fills a 64-bit line in one read.
module cache_controller #(
    parameter int unsigned SET_BITS = 6,
    parameter int unsigned TAG_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    cache_if.slave      mem,
    output logic        sram_r_en,
    output logic        sram_w_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int unsigned Sets = 1 << SET_BITS;

    typedef enum logic [1:0] {StIdle, StRdMiss, StWrThru} state_e;

    state_e state_q, state_d;

    logic [Sets-1:0]     valid_q [2];
    logic [Sets-1:0]     lru_q;
    logic [TAG_BITS-1:0] tag_q   [2][Sets];
    logic [63:0]         data_q  [2][Sets];

    logic [SET_BITS-1:0] set_idx;
    logic [TAG_BITS-1:0] tag_in;
    logic [1:0]          hit;
    logic [63:0]         hit_line;
    logic                victim;
    logic                fill_en;
    logic                inv_en;
    logic                lru_en;
    logic                lru_val;

    assign set_idx  = mem.address[3 +: SET_BITS];
    assign tag_in   = mem.address[3 + SET_BITS +: TAG_BITS];
    assign hit[0]   = valid_q[0][set_idx] && (tag_q[0][set_idx] == tag_in);
    assign hit[1]   = valid_q[1][set_idx] && (tag_q[1][set_idx] == tag_in);
    assign hit_line = hit[1] ? data_q[1][set_idx] : data_q[0][set_idx];

    // Prefer an empty way so LRU only matters once the set is full.
    assign victim = !valid_q[0][set_idx] ? 1'b0 :
                    !valid_q[1][set_idx] ? 1'b1 : lru_q[set_idx];

    assign sram_r_en    = (state_q == StRdMiss);
    assign sram_w_en    = (state_q == StWrThru);
    assign sram_wdata   = mem.wdata;
    assign sram_address = (state_q == StWrThru) ? mem.address
                                                : {mem.address[31:3], 3'b000};

    always_comb begin
        state_d   = state_q;
        mem.ready = 1'b0;
        mem.rdata = '0;
        fill_en   = 1'b0;
        inv_en    = 1'b0;
        lru_en    = 1'b0;
        lru_val   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem.w_en) begin
                    inv_en  = 1'b1;
                    state_d = StWrThru;
                end else if (mem.r_en) begin
                    if (|hit) begin
                        mem.ready = 1'b1;
                        mem.rdata = mem.address[2] ? hit_line[63:32] : hit_line[31:0];
                        lru_en    = 1'b1;
                        lru_val   = ~hit[1];
                    end else begin
                        state_d = StRdMiss;
                    end
                end else begin
                    mem.ready = 1'b1;
                end
            end
            StRdMiss: begin
                if (sram_ready) begin
                    fill_en   = 1'b1;
                    lru_en    = 1'b1;
                    lru_val   = ~victim;
                    mem.ready = 1'b1;
                    // Bypass the returning line so the requester need not re-read.
                    mem.rdata = mem.address[2] ? sram_rdata[63:32] : sram_rdata[31:0];
                    state_d   = StIdle;
                end
            end
            StWrThru: begin
                if (sram_ready) begin
                    mem.ready = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            state_q <= state_d;
            if (inv_en && hit[0]) valid_q[0][set_idx] <= 1'b0;
            if (inv_en && hit[1]) valid_q[1][set_idx] <= 1'b0;
            if (fill_en)          valid_q[victim][set_idx] <= 1'b1;
            if (lru_en)           lru_q[set_idx] <= lru_val;
        end
    end

    // Tag and data need no reset: valid gates every use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[victim][set_idx]  <= tag_in;
            data_q[victim][set_idx] <= sram_rdata;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: hits, misses, LRU eviction, write-through
// invalidation, write priority and reset during a pending miss.
module tb_cache_controller;

    logic        clk;
    logic        rst;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    int n_tests;
    int n_fail;

    cache_if bus ();

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .mem          (bus),
        .sram_r_en    (sram_r_en),
        .sram_w_en    (sram_w_en),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read at addr; a hit must answer in the same cycle, a miss after one SRAM read.
    task automatic read_op(input string tag, input logic [31:0] addr, input bit exp_hit,
                           input logic [63:0] line, input logic [31:0] exp_word);
        @(negedge clk);
        bus.r_en    = 1'b1;
        bus.w_en    = 1'b0;
        bus.address = addr;
        #1;
        if (exp_hit) begin
            check({tag, " hit ready"}, 64'(bus.ready), 64'd1);
            check({tag, " hit rdata"}, 64'(bus.rdata), 64'(exp_word));
            @(negedge clk);
            check({tag, " hit no sram_r_en"}, 64'(sram_r_en), 64'd0);
            bus.r_en = 1'b0;
        end else begin
            check({tag, " miss ready"}, 64'(bus.ready), 64'd0);
            @(negedge clk);
            check({tag, " sram_r_en"}, 64'(sram_r_en), 64'd1);
            check({tag, " sram_address"}, 64'(sram_address), 64'({addr[31:3], 3'b000}));
            sram_rdata = line;
            sram_ready = 1'b1;
            #1;
            check({tag, " fill ready"}, 64'(bus.ready), 64'd1);
            check({tag, " fill rdata"}, 64'(bus.rdata), 64'(exp_word));
            @(negedge clk);
            sram_ready = 1'b0;
            bus.r_en   = 1'b0;
            #1;
            check({tag, " sram_r_en drop"}, 64'(sram_r_en), 64'd0);
        end
    endtask

    task automatic write_op(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input bit also_read);
        @(negedge clk);
        bus.w_en    = 1'b1;
        bus.r_en    = also_read;
        bus.address = addr;
        bus.wdata   = data;
        #1;
        check({tag, " ready low"}, 64'(bus.ready), 64'd0);
        @(negedge clk);
        check({tag, " sram_w_en"}, 64'(sram_w_en), 64'd1);
        check({tag, " sram_r_en"}, 64'(sram_r_en), 64'd0);
        check({tag, " sram_wdata"}, 64'(sram_wdata), 64'(data));
        check({tag, " sram_address"}, 64'(sram_address), 64'(addr));
        sram_ready = 1'b1;
        #1;
        check({tag, " done ready"}, 64'(bus.ready), 64'd1);
        @(negedge clk);
        sram_ready = 1'b0;
        bus.w_en   = 1'b0;
        bus.r_en   = 1'b0;
        #1;
        check({tag, " sram_w_en drop"}, 64'(sram_w_en), 64'd0);
    endtask

    localparam logic [63:0] Line1 = 64'hBBBB_0002_AAAA_0001;
    localparam logic [63:0] Line3 = 64'h3333_0004_3333_0000;
    localparam logic [63:0] Line5 = 64'h5555_0004_5555_0000;
    localparam logic [63:0] Line9 = 64'h9999_0004_9999_0000;

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.r_en    = 1'b0;
        bus.w_en    = 1'b0;
        bus.address = '0;
        bus.wdata   = '0;
        sram_rdata  = '0;
        sram_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset ready", 64'(bus.ready), 64'd1);
        check("reset sram_r_en", 64'(sram_r_en), 64'd0);
        check("reset sram_w_en", 64'(sram_w_en), 64'd0);
        check("reset rdata", 64'(bus.rdata), 64'd0);

        // Cold miss then same-line hit on the other word.
        read_op("t1 rd 0x100", 32'h100, 1'b0, Line1, 32'hAAAA_0001);
        read_op("t2 rd 0x104", 32'h104, 1'b1, Line1, 32'hBBBB_0002);

        // Set 32 with three tags: 0x500 evicts the LRU way holding 0x100.
        read_op("t3 rd 0x100", 32'h100, 1'b1, Line1, 32'hAAAA_0001);
        read_op("t3 rd 0x300", 32'h300, 1'b0, Line3, 32'h3333_0000);
        read_op("t3 rd 0x500", 32'h500, 1'b0, Line5, 32'h5555_0000);
        read_op("t3 rd 0x300 again", 32'h300, 1'b1, Line3, 32'h3333_0000);
        read_op("t3 rd 0x100 evicted", 32'h100, 1'b0, Line1, 32'hAAAA_0001);

        // Write-through invalidates the cached line.
        write_op("t4 wr 0x104", 32'h104, 32'h0000_1234, 1'b0);
        read_op("t4 rd 0x100 after wr", 32'h100, 1'b0, Line1, 32'hAAAA_0001);

        // Write wins when both enables are set; 0x300 line is invalidated too.
        write_op("t5 wr+rd 0x300", 32'h300, 32'h0000_5678, 1'b1);
        read_op("t5 rd 0x300 after wr", 32'h300, 1'b0, Line3, 32'h3333_0000);
        read_op("t5 rd 0x304 hit", 32'h304, 1'b1, Line3, 32'h3333_0004);

        // Reset while a miss is outstanding.
        @(negedge clk);
        bus.r_en    = 1'b1;
        bus.address = 32'h900;
        sram_rdata  = Line9;
        @(negedge clk);
        check("t6 in rd_miss", 64'(sram_r_en), 64'd1);
        rst = 1'b1;
        #1;
        check("t6 rst sram_r_en", 64'(sram_r_en), 64'd0);
        check("t6 rst miss ready", 64'(bus.ready), 64'd0);
        bus.r_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6 idle ready", 64'(bus.ready), 64'd1);
        check("t6 idle sram_r_en", 64'(sram_r_en), 64'd0);
        read_op("t6 rd 0x304 invalidated", 32'h304, 1'b0, Line3, 32'h3333_0004);
        read_op("t6 rd 0x100 invalidated", 32'h100, 1'b0, Line1, 32'hAAAA_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
